// File: rtl/boreal_cursor_pkg.sv
// Shared types and constants for the cursor report transmitter.
package boreal_cursor_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      SEQ,
      DX,
      DY,
      CSUM
   } state_e;

   localparam int         REPORT_LEN     = 5;
   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
   localparam int         ACC_W          = 32;

   function automatic logic [7:0] frame_csum(input logic [7:0] hdr, input logic [7:0] seq,
                                             input logic [7:0] dx, input logic [7:0] dy);
      return hdr ^ seq ^ dx ^ dy;
   endfunction

endpackage

// File: rtl/boreal_sat_delta.sv
// Splits a Q.FRAC accumulator into a floored, int8-saturated whole delta and the residual it leaves behind.
module boreal_sat_delta
   import boreal_cursor_pkg::*;
#(
   parameter int FRAC = 16
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [7:0]       delta,
   output logic signed [ACC_W-1:0] residual
);

   logic signed [ACC_W-1:0] whole;
   logic signed [ACC_W-1:0] delta_ext;

   always_comb begin
      whole = acc >>> FRAC;
      if (whole > 127) begin
         delta = 8'sd127;
      end else if (whole < -128) begin
         delta = -8'sd128;
      end else begin
         delta = whole[7:0];
      end
      // Saturation excess stays in the residual so no motion is lost.
      delta_ext = {{(ACC_W-8){delta[7]}}, delta};
      residual  = acc - (delta_ext <<< FRAC);
   end

endmodule

// File: rtl/boreal_cursor_report_tx.sv
// Integrates signed Q.FRAC cursor velocities and periodically emits framed
// relative-motion reports (header, seq, dx, dy, checksum) on a byte stream.
module boreal_cursor_report_tx
   import boreal_cursor_pkg::*;
#(
   parameter int         FRAC          = 16,
   parameter int         REPORT_PERIOD = 1000,
   parameter bit         SEND_ZERO     = 1'b1,
   parameter logic [7:0] HEADER        = DEFAULT_HEADER
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid,
   input  logic signed [23:0] vx_in,
   input  logic signed [23:0] vy_in,
   output logic        [7:0]  tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic               busy,
   output logic        [7:0]  overrun
);

   localparam int                     CNT_W    = $clog2(REPORT_PERIOD);
   localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(REPORT_PERIOD - 1);
   localparam logic signed [ACC_W:0]  SUM_MAX  = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0]  SUM_MIN  = -SUM_MAX;

   function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [23:0] v);
      logic signed [ACC_W:0] sum;
      sum = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W-23){v[23]}}, v});
      if (sum > SUM_MAX) begin
         return SUM_MAX[ACC_W-1:0];
      end else if (sum < SUM_MIN) begin
         return SUM_MIN[ACC_W-1:0];
      end
      return sum[ACC_W-1:0];
   endfunction

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
   logic [7:0]              seq_q, seq_d, dx_q, dx_d, dy_q, dy_d;
   logic [7:0]              overrun_q, overrun_d, tx_data_q, tx_data_d;
   logic                    pending_q, pending_d, tx_valid_q, tx_valid_d;

   logic signed [7:0]       dx_new, dy_new;
   logic signed [ACC_W-1:0] res_x, res_y, base_x, base_y;
   logic                    tick, launch, send, hs;

   boreal_sat_delta #(.FRAC(FRAC)) u_delta_x (.acc(acc_x_q), .delta(dx_new), .residual(res_x));
   boreal_sat_delta #(.FRAC(FRAC)) u_delta_y (.acc(acc_y_q), .delta(dy_new), .residual(res_y));

   always_comb begin
      state_d    = state_q;
      seq_d      = seq_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      overrun_d  = overrun_q;
      pending_d  = pending_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;

      tick   = (cnt_q == CNT_LAST);
      cnt_d  = tick ? '0 : cnt_q + 1'b1;
      launch = (state_q == IDLE) && (tick || pending_q);
      send   = launch && (SEND_ZERO || (dx_new != 8'sd0) || (dy_new != 8'sd0));
      hs     = tx_valid_q && tx_ready;

      // A launch removes the reported whole part before this cycle's sample is added.
      base_x  = launch ? res_x : acc_x_q;
      base_y  = launch ? res_y : acc_y_q;
      acc_x_d = valid ? sat_add(base_x, vx_in) : base_x;
      acc_y_d = valid ? sat_add(base_y, vy_in) : base_y;

      if (launch) begin
         pending_d = 1'b0;
      end else if (tick) begin
         pending_d = 1'b1;
         if (pending_q && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
         end
      end

      case (state_q)
         IDLE: if (send) begin
            state_d    = HDR;
            dx_d       = dx_new;
            dy_d       = dy_new;
            tx_data_d  = HEADER;
            tx_valid_d = 1'b1;
         end
         HDR: if (hs) begin
            state_d   = SEQ;
            tx_data_d = seq_q;
         end
         SEQ: if (hs) begin
            state_d   = DX;
            tx_data_d = dx_q;
         end
         DX: if (hs) begin
            state_d   = DY;
            tx_data_d = dy_q;
         end
         DY: if (hs) begin
            state_d   = CSUM;
            tx_data_d = frame_csum(HEADER, seq_q, dx_q, dy_q);
         end
         CSUM: if (hs) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            seq_d      = seq_q + 8'd1;
         end
         default: begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_x_q    <= '0;
         acc_y_q    <= '0;
         seq_q      <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         overrun_q  <= '0;
         pending_q  <= 1'b0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_x_q    <= acc_x_d;
         acc_y_q    <= acc_y_d;
         seq_q      <= seq_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         overrun_q  <= overrun_d;
         pending_q  <= pending_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = (state_q != IDLE);
   assign overrun  = overrun_q;

endmodule
